// File: rtl/dcpu_bus_pkg.sv
// Shared types and constants for the two-master dcpu bus arbiter.
package dcpu_bus_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // dcpu halt opcode, so a timed-out instruction fetch stops the core
    localparam logic [15:0] ERR_DAT_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/dcpu_bus_timeout.sv
// Watchdog counter: expired is high while the count sits at TIMEOUT-1.
// TIMEOUT=0 disables the watchdog, so expired never rises.
module dcpu_bus_timeout #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    if (TIMEOUT > 0) begin : g_wd
        localparam int unsigned CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] count_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_q <= '0;
            end else if (clear) begin
                count_q <= '0;
            end else if (count_en) begin
                count_q <= count_q + CW'(1);
            end
        end

        assign expired = (count_q == CW'(TIMEOUT - 1));
    end else begin : g_off
        assign expired = 1'b0;
    end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin arbiter for a dcpu-style cs/we/addr/dat/ack bus,
// with a watchdog that error-terminates transfers the slave never acks.
module dcpu_bus_arbiter
    import dcpu_bus_pkg::*;
#(
    parameter int unsigned   AW      = 16,
    parameter int unsigned   DW      = 16,
    parameter int unsigned   TIMEOUT = 64,
    parameter logic [DW-1:0] ERR_DAT = DW'(ERR_DAT_DEFAULT)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_m0_cs,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_dat,
    output logic [DW-1:0] o_m0_dat,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    input  logic          i_m1_cs,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_dat,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic          o_cs,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_dat,
    input  logic [DW-1:0] i_dat,
    input  logic          i_ack,
    output logic [1:0]    o_grant
);

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;

    logic          sel_cs, sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_dat;
    logic          done, err;
    logic [DW-1:0] rdat;
    logic          wd_clear, wd_en, wd_expired;

    assign sel_cs   = (owner_q == M1) ? i_m1_cs   : i_m0_cs;
    assign sel_we   = (owner_q == M1) ? i_m1_we   : i_m0_we;
    assign sel_addr = (owner_q == M1) ? i_m1_addr : i_m0_addr;
    assign sel_dat  = (owner_q == M1) ? i_m1_dat  : i_m0_dat;

    dcpu_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (i_clk),
        .reset    (i_reset),
        .clear    (wd_clear),
        .count_en (wd_en),
        .expired  (wd_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            owner_q <= M0;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        o_cs     = 1'b0;
        o_we     = 1'b0;
        o_addr   = '0;
        o_dat    = '0;
        o_grant  = 2'b00;
        done     = 1'b0;
        err      = 1'b0;
        rdat     = '0;
        wd_clear = 1'b1;
        wd_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_m0_cs || i_m1_cs) begin
                    state_d = BUSY;
                    if (i_m0_cs && i_m1_cs) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = i_m1_cs ? M1 : M0;
                    end
                end
            end
            BUSY: begin
                o_cs    = sel_cs;
                o_we    = sel_we;
                o_addr  = sel_addr;
                o_dat   = sel_dat;
                o_grant = (owner_q == M1) ? 2'b10 : 2'b01;
                // Owner abandoned the request: end silently, fairness state untouched
                if (!sel_cs) begin
                    state_d = IDLE;
                end else if (i_ack) begin
                    done    = 1'b1;
                    rdat    = i_dat;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    rdat    = ERR_DAT;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    wd_clear = 1'b0;
                    wd_en    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        o_m0_ack = done && (owner_q == M0);
        o_m0_err = err  && (owner_q == M0);
        o_m0_dat = (done && (owner_q == M0)) ? rdat : '0;
        o_m1_ack = done && (owner_q == M1);
        o_m1_err = err  && (owner_q == M1);
        o_m1_dat = (done && (owner_q == M1)) ? rdat : '0;
    end

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Directed bench: a per-cycle vector table for plain transfers and arbitration,
// then hand sequences for watchdog, async reset and request withdrawal.
module tb_dcpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_m0_cs, i_m0_we, i_m1_cs, i_m1_we, i_ack;
    logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat, i_dat;
    logic [15:0] o_m0_dat, o_m1_dat, o_addr, o_dat;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_cs, o_we;
    logic [1:0]  o_grant;

    always #5 clk = ~clk;

    dcpu_bus_arbiter #(
        .AW      (16),
        .DW      (16),
        .TIMEOUT (8),
        .ERR_DAT (16'hFFFF)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_m0_cs   (i_m0_cs),
        .i_m0_we   (i_m0_we),
        .i_m0_addr (i_m0_addr),
        .i_m0_dat  (i_m0_dat),
        .o_m0_dat  (o_m0_dat),
        .o_m0_ack  (o_m0_ack),
        .o_m0_err  (o_m0_err),
        .i_m1_cs   (i_m1_cs),
        .i_m1_we   (i_m1_we),
        .i_m1_addr (i_m1_addr),
        .i_m1_dat  (i_m1_dat),
        .o_m1_dat  (o_m1_dat),
        .o_m1_ack  (o_m1_ack),
        .o_m1_err  (o_m1_err),
        .o_cs      (o_cs),
        .o_we      (o_we),
        .o_addr    (o_addr),
        .o_dat     (o_dat),
        .i_dat     (i_dat),
        .i_ack     (i_ack),
        .o_grant   (o_grant)
    );

    typedef struct packed {
        logic        m0_cs;
        logic        m0_we;
        logic [15:0] m0_addr;
        logic [15:0] m0_dat;
        logic        m1_cs;
        logic        m1_we;
        logic [15:0] m1_addr;
        logic [15:0] m1_dat;
        logic [15:0] s_dat;
        logic        s_ack;
    } ins_t;

    typedef struct packed {
        logic        cs;
        logic        we;
        logic [15:0] addr;
        logic [15:0] dat;
        logic [1:0]  grant;
        logic        m0_ack;
        logic        m0_err;
        logic [15:0] m0_dat;
        logic        m1_ack;
        logic        m1_err;
        logic [15:0] m1_dat;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    localparam int NVEC = 15;

    vec_t  vecs [NVEC];
    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t zo;
    outs_t e;

    function automatic ins_t mi(logic m0c, logic m0w, logic [15:0] m0a, logic [15:0] m0d,
                                logic m1c, logic m1w, logic [15:0] m1a, logic [15:0] m1d,
                                logic [15:0] sd, logic sa);
        ins_t r;
        r = '{m0_cs: m0c, m0_we: m0w, m0_addr: m0a, m0_dat: m0d,
              m1_cs: m1c, m1_we: m1w, m1_addr: m1a, m1_dat: m1d, s_dat: sd, s_ack: sa};
        return r;
    endfunction

    function automatic outs_t mo(logic cs, logic we, logic [15:0] addr, logic [15:0] dat,
                                 logic [1:0] gr, logic a0, logic e0, logic [15:0] d0,
                                 logic a1, logic e1, logic [15:0] d1);
        outs_t r;
        r = '{cs: cs, we: we, addr: addr, dat: dat, grant: gr, m0_ack: a0, m0_err: e0,
              m0_dat: d0, m1_ack: a1, m1_err: e1, m1_dat: d1};
        return r;
    endfunction

    task automatic drive(input ins_t v);
        i_m0_cs   = v.m0_cs;
        i_m0_we   = v.m0_we;
        i_m0_addr = v.m0_addr;
        i_m0_dat  = v.m0_dat;
        i_m1_cs   = v.m1_cs;
        i_m1_we   = v.m1_we;
        i_m1_addr = v.m1_addr;
        i_m1_dat  = v.m1_dat;
        i_dat     = v.s_dat;
        i_ack     = v.s_ack;
    endtask

    task automatic check(input string name, input outs_t x);
        outs_t a;
        a = mo(o_cs, o_we, o_addr, o_dat, o_grant, o_m0_ack, o_m0_err, o_m0_dat,
               o_m1_ack, o_m1_err, o_m1_dat);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got cs=%b we=%b addr=%h dat=%h gnt=%b m0=%b/%b/%h m1=%b/%b/%h; want cs=%b we=%b addr=%h dat=%h gnt=%b m0=%b/%b/%h m1=%b/%b/%h",
                     name, a.cs, a.we, a.addr, a.dat, a.grant, a.m0_ack, a.m0_err, a.m0_dat,
                     a.m1_ack, a.m1_err, a.m1_dat, x.cs, x.we, x.addr, x.dat, x.grant,
                     x.m0_ack, x.m0_err, x.m0_dat, x.m1_ack, x.m1_err, x.m1_dat);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        zo = '0;

        // m0 read; slave ack in IDLE must be ignored, then acks second BUSY cycle
        vecs[0]  = '{mi(1, 0, 16'h0010, 0, 0, 0, 0, 0, 16'h1234, 1), zo};
        vecs[1]  = '{mi(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0, 0),
                     mo(1, 0, 16'h0010, 0, 2'b01, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{mi(1, 0, 16'h0010, 0, 0, 0, 0, 0, 16'h1234, 1),
                     mo(1, 0, 16'h0010, 0, 2'b01, 1, 0, 16'h1234, 0, 0, 0)};
        vecs[3]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zo};
        // m1 write
        vecs[4]  = '{mi(0, 0, 0, 0, 1, 1, 16'h0100, 16'hBEEF, 0, 0), zo};
        vecs[5]  = '{mi(0, 0, 0, 0, 1, 1, 16'h0100, 16'hBEEF, 0, 0),
                     mo(1, 1, 16'h0100, 16'hBEEF, 2'b10, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{mi(0, 0, 0, 0, 1, 1, 16'h0100, 16'hBEEF, 0, 1),
                     mo(1, 1, 16'h0100, 16'hBEEF, 2'b10, 0, 0, 0, 1, 0, 0)};
        vecs[7]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zo};
        // both request continuously: m0, m1, m0 with one idle cycle between
        vecs[8]  = '{mi(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0, 0, 0), zo};
        vecs[9]  = '{mi(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0, 16'hAAAA, 1),
                     mo(1, 0, 16'h0020, 0, 2'b01, 1, 0, 16'hAAAA, 0, 0, 0)};
        vecs[10] = '{mi(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0, 0, 0), zo};
        vecs[11] = '{mi(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0, 16'hBBBB, 1),
                     mo(1, 0, 16'h0030, 0, 2'b10, 0, 0, 0, 1, 0, 16'hBBBB)};
        vecs[12] = '{mi(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0, 0, 0), zo};
        vecs[13] = '{mi(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0, 16'hCCCC, 1),
                     mo(1, 0, 16'h0020, 0, 2'b01, 1, 0, 16'hCCCC, 0, 0, 0)};
        vecs[14] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), zo};

        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        i_reset = 1'b1;
        #2;
        check("reset", zo);
        @(negedge clk);
        i_reset = 1'b0;

        for (int k = 0; k < NVEC; k++) begin
            tick();
            drive(vecs[k].i);
            #1;
            check($sformatf("vec%0d", k), vecs[k].o);
        end

        // Watchdog: 8th BUSY cycle without ack terminates with error
        tick();
        drive(mi(1, 0, 16'h0040, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("to_req", zo);
        e = mo(1, 0, 16'h0040, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), e);
        end
        tick();
        check("to_expire", mo(1, 0, 16'h0040, 0, 2'b01, 1, 1, 16'hFFFF, 0, 0, 0));
        tick();
        i_m0_cs = 1'b0;
        #1;
        check("to_idle", zo);

        // Ack arriving on the expiry cycle wins over the error
        tick();
        i_m0_cs = 1'b1;
        #1;
        check("tack_req", zo);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("tack_wait%0d", k), e);
        end
        tick();
        i_ack = 1'b1;
        i_dat = 16'h1111;
        #1;
        check("tack_ack", mo(1, 0, 16'h0040, 0, 2'b01, 1, 0, 16'h1111, 0, 0, 0));
        tick();
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("tack_idle", zo);

        // Async reset mid-BUSY; last was m0, so only reset makes m0 win the tie
        tick();
        drive(mi(1, 0, 16'h0050, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst_req", zo);
        tick();
        check("rst_busy", mo(1, 0, 16'h0050, 0, 2'b01, 0, 0, 0, 0, 0, 0));
        #1;
        i_ack   = 1'b1;
        i_dat   = 16'h9999;
        i_reset = 1'b1;
        #1;
        check("rst_async", zo);
        #1;
        i_reset = 1'b0;
        drive(mi(1, 0, 16'h0050, 0, 1, 0, 16'h0060, 0, 0, 0));
        #1;
        check("rst_idle", zo);
        tick();
        check("rst_tie", mo(1, 0, 16'h0050, 0, 2'b01, 0, 0, 0, 0, 0, 0));
        i_ack = 1'b1;
        i_dat = 16'h2222;
        #1;
        check("rst_ack", mo(1, 0, 16'h0050, 0, 2'b01, 1, 0, 16'h2222, 0, 0, 0));

        // m1 withdraws while granted; pending m0 follows
        tick();
        i_ack = 1'b0;
        i_dat = 16'h0000;
        #1;
        check("drop_idle", zo);
        tick();
        check("drop_gnt", mo(1, 0, 16'h0060, 0, 2'b10, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mi(1, 0, 16'h0050, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("drop_cut", mo(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0));
        tick();
        check("drop_idle2", zo);
        tick();
        check("drop_pend", mo(1, 0, 16'h0050, 0, 2'b01, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
